// File: rtl/prefetch_queue_if.sv
// -----------------------------------------------------------------------------
// prefetch_queue_if
// Groups the prefetch-engine push side, the decoder pop side and the status
// flags of prefetch_queue into one bundle.
//   master : the prefetch engine / decoder pair (drives pushes and pops)
//   slave  : the queue itself
// Signals:
//   pr_reset        flush contents and sticky state
//   signal_limit_do push a GP (limit) fault marker
//   signal_pf_do    push a page-fault marker
//   write_do        push a data entry
//   write_data      {len, data} entry to push
//   accept_do       consumer pops the head entry
//   accept_data     head entry, or bypassed write_data
//   accept_empty    no entry available to the consumer
//   used            stored entry count, 0..DEPTH
//   almost_full     back-pressure hint
//   fault_pending   fault marker queued; pushes blocked
//   overflow        sticky: a push was dropped while full
// -----------------------------------------------------------------------------
interface prefetch_queue_if #(
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 4,
   parameter int DEPTH_LOG2 = 4
);
   logic                    pr_reset;
   logic                    signal_limit_do;
   logic                    signal_pf_do;
   logic                    write_do;
   logic [LEN_W+DATA_W-1:0] write_data;
   logic                    accept_do;
   logic [LEN_W+DATA_W-1:0] accept_data;
   logic                    accept_empty;
   logic [DEPTH_LOG2:0]     used;
   logic                    almost_full;
   logic                    fault_pending;
   logic                    overflow;

   modport master (
      output pr_reset, signal_limit_do, signal_pf_do, write_do, write_data,
             accept_do,
      input  accept_data, accept_empty, used, almost_full, fault_pending,
             overflow
   );

   modport slave (
      input  pr_reset, signal_limit_do, signal_pf_do, write_do, write_data,
             accept_do,
      output accept_data, accept_empty, used, almost_full, fault_pending,
             overflow
   );
endinterface

// File: rtl/prefetch_queue.sv
// -----------------------------------------------------------------------------
// prefetch_queue
// Show-ahead queue of {length, data} entries between the prefetch engine and
// the decoder's byte consumer. Fault markers are entries whose length field
// carries GP_CODE or PF_CODE; once one is queued, further pushes are ignored
// until a flush. An empty-queue write can be handed straight to the consumer
// (BYPASS_EN). Storage is a plain register array indexed by wrapping pointers;
// full/empty are decided by the entry count, not by pointer comparison.
// Ports:
//   clk    clock
//   rst_n  synchronous active-low reset, sampled on rising clk
//   bus    prefetch_queue_if.slave (push/pop handshake and status flags)
// -----------------------------------------------------------------------------
module prefetch_queue #(
   parameter int DATA_W     = 32,
   parameter int LEN_W      = 4,
   parameter int DEPTH_LOG2 = 4,
   parameter int AF_MARGIN  = 2,
   parameter bit BYPASS_EN  = 1'b1,
   parameter int GP_CODE    = 15,
   parameter int PF_CODE    = 14
) (
   input  logic             clk,
   input  logic             rst_n,
   prefetch_queue_if.slave  bus
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int W     = LEN_W + DATA_W;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0] AF_CNT   = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
   localparam logic [LEN_W-1:0]    GP_LEN   = LEN_W'(GP_CODE);
   localparam logic [LEN_W-1:0]    PF_LEN   = LEN_W'(PF_CODE);

   logic [W-1:0]            mem_q [DEPTH];
   logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2:0]     used_q, used_d;
   logic                    fault_q, fault_d;
   logic                    ovf_q, ovf_d;

   logic                    fault_req;
   logic                    push_req;
   logic [W-1:0]            push_entry;
   logic                    stored_empty;
   logic                    full;
   logic                    bypass;
   logic                    head_empty;
   logic                    pop;
   logic                    bypass_take;
   logic                    do_pop;
   logic                    do_store;

   // NOTE: every signal gets a default at the top of always_comb so no path
   // leaves it unassigned; that is what keeps this block free of latches.
   always_comb begin
      fault_req    = bus.signal_limit_do | bus.signal_pf_do;
      push_req     = (fault_req | bus.write_do) & ~fault_q;
      push_entry   = bus.write_data;
      stored_empty = (used_q == '0);
      full         = (used_q == FULL_CNT);

      // Limit has priority over page fault, which has priority over data.
      if (bus.signal_limit_do) begin
         push_entry = {GP_LEN, {DATA_W{1'b0}}};
      end else if (bus.signal_pf_do) begin
         push_entry = {PF_LEN, {DATA_W{1'b0}}};
      end

      bypass = BYPASS_EN && stored_empty && bus.write_do && !fault_req &&
               !fault_q && !bus.pr_reset;
      head_empty  = stored_empty && !bypass;
      pop         = bus.accept_do && !head_empty;
      // A bypassed write that is consumed at once never touches the array.
      bypass_take = bypass && bus.accept_do;
      do_pop      = pop && !bypass_take;
      // A full queue still takes a push when the same cycle frees a slot.
      do_store    = push_req && !bypass_take && (!full || do_pop);

      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      used_d   = used_q;
      fault_d  = fault_q;
      ovf_d    = ovf_q;

      if (bus.pr_reset) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         used_d   = '0;
         fault_d  = 1'b0;
         ovf_d    = 1'b0;
      end else begin
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         if (do_store) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (fault_req) begin
               fault_d = 1'b1;
            end
         end else if (push_req && full) begin
            ovf_d = 1'b1;
         end
         case ({do_store, do_pop})
            2'b10:   used_d = used_q + 1'b1;
            2'b01:   used_d = used_q - 1'b1;
            default: used_d = used_q;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         used_q   <= '0;
         fault_q  <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         used_q   <= used_d;
         fault_q  <= fault_d;
         ovf_q    <= ovf_d;
      end
   end

   // NOTE: the entry array has no reset; the count and pointers alone decide
   // which slots are valid, so clearing data would only cost reset routing.
   always_ff @(posedge clk) begin
      if (rst_n && !bus.pr_reset && do_store) begin
         mem_q[wr_ptr_q] <= push_entry;
      end
   end

   assign bus.accept_data   = bypass ? bus.write_data : mem_q[rd_ptr_q];
   assign bus.accept_empty  = head_empty;
   assign bus.used          = used_q;
   assign bus.almost_full   = (used_q >= AF_CNT);
   assign bus.fault_pending = fault_q;
   assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_prefetch_queue.sv
// -----------------------------------------------------------------------------
// tb_prefetch_queue
// Bench for prefetch_queue. A queue-based model tracks the bypass instance and
// is compared against it every cycle; directed sequences pin key behaviours
// with literal values, then a long randomized phase exercises mixed traffic.
// A second instance with BYPASS_EN=0 is checked with directed literals only.
// -----------------------------------------------------------------------------
module tb_prefetch_queue;
   localparam int DW = 32;
   localparam int LW = 4;
   localparam int DL = 4;
   localparam int EW = LW + DW;
   localparam logic [LW-1:0] GP = 4'd15;
   localparam logic [LW-1:0] PF = 4'd14;

   logic clk;
   logic rst_n;

   prefetch_queue_if #(.DATA_W(DW), .LEN_W(LW), .DEPTH_LOG2(DL)) if1 ();
   prefetch_queue_if #(.DATA_W(DW), .LEN_W(LW), .DEPTH_LOG2(DL)) if2 ();

   prefetch_queue #(.BYPASS_EN(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   prefetch_queue #(.BYPASS_EN(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

   int n_tests = 0;
   int n_fail  = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of dut1 ----------------
   logic [EW-1:0] mq[$];
   bit            m_fp;
   bit            m_ovf;
   bit            m_valid = 1'b0;

   always @(negedge clk) begin
      bit            byp, e_empty, pop, push, full;
      logic [EW-1:0] entry;
      byp = (mq.size() == 0) && if1.write_do && !if1.signal_limit_do &&
            !if1.signal_pf_do && !m_fp && !if1.pr_reset;
      e_empty = (mq.size() == 0) && !byp;
      if (m_valid) begin
         check("m_empty", 64'(if1.accept_empty), 64'(e_empty));
         if (!e_empty)
            check("m_data", 64'(if1.accept_data), 64'(byp ? if1.write_data : mq[0]));
         check("m_used", 64'(if1.used), 64'(mq.size()));
         check("m_af", 64'(if1.almost_full), 64'(mq.size() >= 14));
         check("m_fp", 64'(if1.fault_pending), 64'(m_fp));
         check("m_ovf", 64'(if1.overflow), 64'(m_ovf));
      end
      // Advance the model to the state after the coming rising edge.
      if (!rst_n || if1.pr_reset) begin
         mq.delete();
         m_fp  = 1'b0;
         m_ovf = 1'b0;
         if (!rst_n) m_valid = 1'b1;
      end else if (!(byp && if1.accept_do)) begin
         pop   = if1.accept_do && !e_empty;
         push  = (if1.signal_limit_do || if1.signal_pf_do || if1.write_do) && !m_fp;
         full  = (mq.size() == 16);
         entry = if1.signal_limit_do ? {GP, 32'd0} :
                 if1.signal_pf_do    ? {PF, 32'd0} : if1.write_data;
         if (pop) void'(mq.pop_front());
         if (push) begin
            if (!full || pop) begin
               mq.push_back(entry);
               if (if1.signal_limit_do || if1.signal_pf_do) m_fp = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      if1.pr_reset = 0; if1.signal_limit_do = 0; if1.signal_pf_do = 0;
      if1.write_do = 0; if1.write_data = '0; if1.accept_do = 0;
      if2.pr_reset = 0; if2.signal_limit_do = 0; if2.signal_pf_do = 0;
      if2.write_do = 0; if2.write_data = '0; if2.accept_do = 0;
   endtask

   task automatic drv(input bit lim, input bit pf, input bit wr,
                      input logic [EW-1:0] d, input bit acc, input bit prr);
      if1.signal_limit_do = lim; if1.signal_pf_do = pf; if1.write_do = wr;
      if1.write_data = d; if1.accept_do = acc; if1.pr_reset = prr;
   endtask

   // Returns at posedge+2 with inputs idled; outputs settled and stable.
   task automatic tick();
      @(posedge clk);
      #1;
      idle();
      #1;
   endtask

   task automatic push_n(input int n, input logic [LW-1:0] len);
      for (int i = 0; i < n; i++) begin
         drv(0, 0, 1, {len, 32'(i)}, 0, 0);
         tick();
      end
   endtask

   initial begin
      logic [EW-1:0] rd;
      idle();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;

      // Reset state
      check("rst_used", 64'(if1.used), 64'd0);
      check("rst_empty", 64'(if1.accept_empty), 64'd1);
      check("rst_af", 64'(if1.almost_full), 64'd0);
      check("rst_fp", 64'(if1.fault_pending), 64'd0);
      check("rst_ovf", 64'(if1.overflow), 64'd0);

      // Single stored entry, then pop
      drv(0, 0, 1, {4'd4, 32'h11223344}, 0, 0);
      tick();
      check("t1_used", 64'(if1.used), 64'd1);
      check("t1_empty", 64'(if1.accept_empty), 64'd0);
      check("t1_data", 64'(if1.accept_data), 64'h4_1122_3344);
      drv(0, 0, 0, '0, 1, 0);
      tick();
      check("t1_used_pop", 64'(if1.used), 64'd0);
      check("t1_empty_pop", 64'(if1.accept_empty), 64'd1);

      // Bypass on empty queue
      drv(0, 0, 1, {4'd2, 32'hCAFEBABE}, 1, 0);
      #1;
      check("t2_byp_data", 64'(if1.accept_data), 64'h2_CAFE_BABE);
      check("t2_byp_empty", 64'(if1.accept_empty), 64'd0);
      tick();
      check("t2_used", 64'(if1.used), 64'd0);
      check("t2_empty", 64'(if1.accept_empty), 64'd1);

      // Fill, overflow, push+pop while full, drain across wrap
      for (int i = 0; i < 16; i++) begin
         drv(0, 0, 1, {4'd1, 32'(i)}, 0, 0);
         tick();
         if (i == 12) check("t3_af_13", 64'(if1.almost_full), 64'd0);
         if (i == 13) check("t3_af_14", 64'(if1.almost_full), 64'd1);
      end
      check("t3_used_full", 64'(if1.used), 64'd16);
      drv(0, 0, 1, {4'd1, 32'd99}, 0, 0);
      tick();
      check("t3_used_drop", 64'(if1.used), 64'd16);
      check("t3_ovf", 64'(if1.overflow), 64'd1);
      check("t3_head0", 64'(if1.accept_data), 64'h1_0000_0000);
      drv(0, 0, 1, {4'd1, 32'd100}, 1, 0);
      tick();
      check("t3_used_pp", 64'(if1.used), 64'd16);
      check("t3_head1", 64'(if1.accept_data), 64'h1_0000_0001);
      for (int k = 1; k < 16; k++) begin
         check("t3_drain", 64'(if1.accept_data), {28'd0, 4'd1, 32'(k)});
         drv(0, 0, 0, '0, 1, 0);
         tick();
      end
      check("t3_last", 64'(if1.accept_data), 64'h1_0000_0064);
      drv(0, 0, 0, '0, 1, 0);
      tick();
      check("t3_empty", 64'(if1.accept_empty), 64'd1);
      drv(0, 0, 0, '0, 0, 1);
      tick();
      check("t3_ovf_clr", 64'(if1.overflow), 64'd0);

      // Fault stop
      drv(0, 0, 1, {4'd5, 32'hA0}, 0, 0); tick();
      drv(0, 0, 1, {4'd6, 32'hA1}, 0, 0); tick();
      drv(0, 0, 1, {4'd7, 32'hA2}, 0, 0); tick();
      drv(1, 0, 1, {4'd3, 32'hFF}, 0, 0); tick();
      check("t4_fp", 64'(if1.fault_pending), 64'd1);
      check("t4_used", 64'(if1.used), 64'd4);
      drv(0, 1, 1, {4'd3, 32'hEE}, 0, 0); tick();
      check("t4_used_blk", 64'(if1.used), 64'd4);
      check("t4_ovf", 64'(if1.overflow), 64'd0);
      check("t4_pop0", 64'(if1.accept_data), 64'h5_0000_00A0);
      drv(0, 0, 0, '0, 1, 0); tick();
      check("t4_pop1", 64'(if1.accept_data), 64'h6_0000_00A1);
      drv(0, 0, 0, '0, 1, 0); tick();
      check("t4_pop2", 64'(if1.accept_data), 64'h7_0000_00A2);
      drv(0, 0, 0, '0, 1, 0); tick();
      check("t4_pop_gp", 64'(if1.accept_data), 64'hF_0000_0000);
      drv(0, 0, 0, '0, 1, 0); tick();
      check("t4_empty", 64'(if1.accept_empty), 64'd1);

      // Flush with fault_pending and overflow both set
      drv(0, 0, 0, '0, 0, 1); tick();
      push_n(16, 4'd8);
      drv(0, 0, 1, {4'd8, 32'd77}, 0, 0); tick();
      drv(1, 0, 0, '0, 1, 0); tick();
      check("t5_fp", 64'(if1.fault_pending), 64'd1);
      check("t5_ovf", 64'(if1.overflow), 64'd1);
      for (int i = 0; i < 11; i++) begin
         drv(0, 0, 0, '0, 1, 0); tick();
      end
      check("t5_used5", 64'(if1.used), 64'd5);
      drv(0, 0, 1, {4'd9, 32'h55}, 0, 1);
      #1;
      check("t5_prr_empty", 64'(if1.accept_empty), 64'd0);
      tick();
      check("t5_used", 64'(if1.used), 64'd0);
      check("t5_fp_clr", 64'(if1.fault_pending), 64'd0);
      check("t5_ovf_clr", 64'(if1.overflow), 64'd0);
      check("t5_empty", 64'(if1.accept_empty), 64'd1);
      tick();
      check("t5_nothing", 64'(if1.used), 64'd0);

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         rd = {4'($urandom_range(0, 13)), 32'($urandom)};
         drv($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 2,
             $urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 70 : 35), rd,
             $urandom_range(0, 99) < ((c / 300) % 2 == 0 ? 35 : 70),
             $urandom_range(0, 99) < 3);
         rst_n = ($urandom_range(0, 199) != 0);
         @(posedge clk);
         #1;
      end
      idle();
      rst_n = 1'b1;
      tick();

      // No-bypass instance
      if2.write_do = 1; if2.accept_do = 1; if2.write_data = {4'd3, 32'hDEADBEEF};
      #1;
      check("t6_empty_nb", 64'(if2.accept_empty), 64'd1);
      tick();
      check("t6_used", 64'(if2.used), 64'd1);
      check("t6_data", 64'(if2.accept_data), 64'h3_DEAD_BEEF);
      if2.accept_do = 1;
      tick();
      check("t6_used_pop", 64'(if2.used), 64'd0);
      check("t6_empty", 64'(if2.accept_empty), 64'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/prefetch_queue.md
Name: prefetch_queue

Overview:
Parametrised show-ahead prefetch queue between the prefetch engine and the decoder's instruction-byte consumer. It stores {length, data} entries and has an optional empty-queue bypass. Fault markers (GP limit, page fault) are encoded in the length field. Adds configurable width/depth, a sticky fault stop, almost-full back-pressure, overflow detection and an internal register array with no external FIFO primitive.

Parameters:
DATA_W, 32, data bits per entry
LEN_W, 4, length/code bits per entry
DEPTH_LOG2, 4, log2 of entry count (DEPTH = 16)
AF_MARGIN, 2, almost_full asserts when used >= DEPTH - AF_MARGIN
BYPASS_EN, 1, 1 = empty-queue write may be consumed in the same cycle
GP_CODE, 15, length code marking a GP (limit) fault entry
PF_CODE, 14, length code marking a page-fault entry

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset, sampled on rising clk
pr_reset  in  1  synchronous flush of contents and sticky state
signal_limit_do  in  1  push GP fault marker
signal_pf_do  in  1  push PF fault marker
write_do  in  1  push data entry
write_data  in  LEN_W+DATA_W  {len, data}
accept_do  in  1  consumer pops head entry
accept_data  out  LEN_W+DATA_W  head entry, or bypassed write_data
accept_empty  out  1  no entry available to consumer
used  out  DEPTH_LOG2+1  stored entry count, 0..DEPTH
almost_full  out  1  back-pressure hint to prefetch engine
fault_pending  out  1  fault marker queued; writes blocked
overflow  out  1  sticky: a push was dropped while full

Behaviour:
- Reset (rst_n=0 at edge): rd_ptr = wr_ptr = 0, used = 0, fault_pending = 0, overflow = 0. Outputs therefore read accept_empty=1, almost_full=0 and accept_data=mem[0]; the value of mem[0] is don't-care. The array itself is not reset.
- pr_reset=1 (rst_n=1): same clears as reset. It overrides any same-cycle push or pop. accept_empty is still driven combinationally that cycle. Bypass is suppressed while pr_reset=1.
- Push source priority: signal_limit_do > signal_pf_do > write_do.
  - Limit pushes {GP_CODE, 0}.
  - PF pushes {PF_CODE, 0}.
  - Only one entry is pushed per cycle.
- Fault stop:
  - A fault marker push that is accepted sets fault_pending on the next edge.
  - While fault_pending=1, all pushes, data and fault alike, are ignored and do not set overflow.
  - Only pr_reset or rst_n clears it.
- Bypass (BYPASS_EN=1):
  - Bypass condition: empty and write_do and no fault signal and fault_pending=0.
  - When it holds, accept_data = write_data and accept_empty = 0, both combinationally.
  - If accept_do=1 in that cycle, the entry is consumed and not stored; used stays 0.
  - If accept_do=0, the entry is stored normally.
  - BYPASS_EN=0: accept_empty = (used==0) and accept_data = mem[rd_ptr].
- Pop:
  - accept_do with accept_empty=1 is ignored.
  - Otherwise rd_ptr increments modulo DEPTH.
  - Show-ahead: the next head is visible on the cycle after the pop.
- Full:
  - A push with used==DEPTH and no same-cycle pop is dropped and sets overflow.
  - A push and pop in the same cycle while full both succeed; used stays DEPTH.
- Simultaneous push and pop (non-bypass): both pointers advance and used is unchanged.
- Wrap-around: pointers are DEPTH_LOG2 bits and wrap naturally. Full/empty are decided by used, not by pointer compare.
- almost_full is combinational from registered used.
- Latency: a stored entry is visible at accept_data one cycle after its push edge. Bypass latency is 0 cycles.

Test Plan:
- Reset, then push {4'd4,32'h11223344} with accept_do=0 -> next cycle used=1, accept_empty=0, accept_data={4'd4,32'h11223344}; pop -> used=0, accept_empty=1.
- Empty queue, write_do and accept_do in the same cycle with {4'd2,32'hCAFEBABE} -> accept_data equals the input the same cycle, accept_empty=0; next cycle used=0.
- 16 pushes of values 0..15 with no pop -> used=16, almost_full=1 from used=14. A 17th push -> dropped, overflow=1. A push+pop while full -> used stays 16, head advances to 1. Draining then returns 1..15 followed by the push+pop value, checking wrap-around.
- Push 3 data entries, then signal_limit_do and write_do in the same cycle -> {GP_CODE,0} is stored, fault_pending=1. Further write_do and signal_pf_do -> used stays 4. Pops return the 3 data entries then {4'd15,0}.
- Queue holding 5 entries with fault_pending=1 and overflow=1, then pr_reset with a same-cycle write_do -> used=0, fault_pending=0, overflow=0, accept_empty=1, nothing stored.
- BYPASS_EN=0 instance, write_do+accept_do on empty -> accept_empty=1 that cycle; entry is stored and popped on the following cycle.
